// File: rtl/instr_line_buffer_if.sv
// Bus bundle for the instruction line buffer: DMA line push side, decode issue
// side and the flush/redirect controls. The DUT uses slave; the fetch/decode side uses master.
interface instr_line_buffer_if #(
    parameter int INW   = 512,
    parameter int DATAW = 16,
    parameter int ADDRW = 32
);
    localparam int NUM_SLOTS = INW / DATAW;
    localparam int SLOTW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [INW-1:0]   line_in;
    logic             line_wr_en;
    logic             line_full;
    logic             line_req;
    logic [DATAW-1:0] instr_out;
    logic [ADDRW-1:0] instr_pc;
    logic             instr_valid;
    logic             instr_ready;
    logic             flush;
    logic [ADDRW-1:0] flush_pc;
    logic [SLOTW-1:0] flush_slot;
    logic             overflow;

    modport slave (
        input  line_in, line_wr_en, instr_ready, flush, flush_pc, flush_slot,
        output line_full, line_req, instr_out, instr_pc, instr_valid, overflow
    );

    modport master (
        output line_in, line_wr_en, instr_ready, flush, flush_pc, flush_slot,
        input  line_full, line_req, instr_out, instr_pc, instr_valid, overflow
    );
endinterface

// File: rtl/instr_line_buffer.sv
// Multi-line instruction prefetch queue: whole lines in, one instruction per
// cycle out with PC tracking, flush/redirect to a mid-line slot, sticky overflow.
module instr_line_buffer #(
    parameter int INW   = 512,
    parameter int DATAW = 16,
    parameter int ADDRW = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    instr_line_buffer_if.slave  bus
);
    localparam int NUM_SLOTS = INW / DATAW;
    localparam int SLOTW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int PTRW      = $clog2(DEPTH);
    localparam int CNTW      = PTRW + 1;

    localparam logic [SLOTW-1:0] LAST_SLOT  = SLOTW'(NUM_SLOTS - 1);
    localparam logic [CNTW-1:0]  FULL_COUNT = CNTW'(DEPTH);
    localparam logic [CNTW-1:0]  REQ_LIMIT  = CNTW'(DEPTH - 1);

    logic [INW-1:0]   mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [SLOTW-1:0] slot_idx_q, slot_idx_d;
    logic [ADDRW-1:0] pc_q, pc_d;
    logic             overflow_q, overflow_d;

    logic             full;
    logic             valid;
    logic             push;
    logic             xfer;
    logic             line_pop;
    logic [INW-1:0]   head_line;
    logic [DATAW-1:0] head_slots [NUM_SLOTS];

    assign full  = (count_q == FULL_COUNT);
    assign valid = (count_q != '0);

    // Flush wins over both push and issue in the same cycle.
    assign push     = bus.line_wr_en && !full && !bus.flush;
    assign xfer     = valid && bus.instr_ready && !bus.flush;
    assign line_pop = xfer && (slot_idx_q == LAST_SLOT);

    assign head_line = mem_q[rd_ptr_q];

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        assign head_slots[gi] = head_line[gi*DATAW +: DATAW];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.line_in;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        slot_idx_d = slot_idx_q;
        pc_d       = pc_q;
        overflow_d = overflow_q;

        if (bus.flush) begin
            // slot_idx lands on flush_slot so the next pushed line starts mid-line.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            slot_idx_d = bus.flush_slot;
            pc_d       = bus.flush_pc;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTRW'(1);
            end

            if (xfer) begin
                pc_d = pc_q + ADDRW'(1);
                if (line_pop) begin
                    slot_idx_d = '0;
                    rd_ptr_d   = rd_ptr_q + PTRW'(1);
                end else begin
                    slot_idx_d = slot_idx_q + SLOTW'(1);
                end
            end

            case ({push, line_pop})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase

            if (bus.line_wr_en && full) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            slot_idx_q <= '0;
            pc_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            slot_idx_q <= slot_idx_d;
            pc_q       <= pc_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.line_full   = full;
    assign bus.line_req    = (count_q < REQ_LIMIT);
    assign bus.instr_valid = valid;
    assign bus.instr_out   = valid ? head_slots[slot_idx_q] : '0;
    assign bus.instr_pc    = pc_q;
    assign bus.overflow    = overflow_q;

endmodule
